mc_sync_fifo: RTL and testbench
===============================

Name: mc_sync_fifo

Overview:
- Single-clock, multi-channel FIFO; next generation of the team's FIFO line.
- NUM_CH independent circular queues share one storage array; each queue has its own pointers, occupancy count and flags.
- Depth need not be a power of two (default 333 per channel).
- Sits between the producer and consumer models/engines; the caller selects a channel per access.

Parameters:
- DATA_WIDTH, 8, bits per entry.
- MEM_DEPTH, 333, entries per channel (any value >= 2).
- NUM_CH, 4, number of channels (>= 2).
- AFULL_THRESH, 320, ALMOST_FULL[c] asserts when count[c] >= AFULL_THRESH.
- AEMPTY_THRESH, 8, ALMOST_EMPTY[c] asserts when count[c] <= AEMPTY_THRESH.

Ports:
- CLK  in  1  single clock.
- RST_n  in  1  asynchronous, active-low reset.
- W_EN  in  1  write request.
- W_CH  in  CHW=$clog2(NUM_CH)  write channel select.
- DATA_IN  in  DATA_WIDTH  write data.
- R_EN  in  1  read request.
- R_CH  in  CHW  read channel select.
- CLR_ERR  in  1  clears all sticky error bits.
- DATA_OUT  out  DATA_WIDTH  read data.
- DATA_VALID  out  1  DATA_OUT holds valid read data.
- FULL  out  NUM_CH  per-channel full flag.
- EMPTY  out  NUM_CH  per-channel empty flag.
- ALMOST_FULL  out  NUM_CH  per-channel threshold flag.
- ALMOST_EMPTY  out  NUM_CH  per-channel threshold flag.
- OVERFLOW  out  NUM_CH  sticky: write was dropped.
- UNDERFLOW  out  NUM_CH  sticky: read was rejected.

Behaviour:
- Reset values (async, RST_n=0):
  - all wr_ptr/rd_ptr/count = 0.
  - EMPTY all 1, ALMOST_EMPTY all 1, FULL and ALMOST_FULL all 0.
  - OVERFLOW and UNDERFLOW all 0.
  - DATA_OUT = 0, DATA_VALID = 0.
  - Memory contents are not reset.
- Reset mid-operation discards every queue immediately; the first accepted write after release lands at entry 0 of its channel.
- Write acceptance: W_EN & (~FULL[W_CH] | (R_EN & R_CH==W_CH & ~EMPTY[R_CH])).
  - An accepted write stores mem[W_CH][wr_ptr] and advances the pointer.
  - A rejected write sets OVERFLOW[W_CH]; data is dropped and the pointer is unchanged.
- Read acceptance: R_EN & ~EMPTY[R_CH].
  - A rejected read sets UNDERFLOW[R_CH] and returns no data.
  - No write-to-read bypass on an empty channel: a read of empty channel c is rejected even if the same cycle writes c.
- Pointers wrap from MEM_DEPTH-1 to 0 by explicit compare, not by modulo 2^n.
- count[c] has width $clog2(MEM_DEPTH+1).
  - Accepted write only: +1. Accepted read only: -1. Both on the same channel: unchanged.
  - Write and read on different channels update both channels independently in the same cycle.
- Flags are registered and updated from next-state count, so they are valid the cycle after the access:
  - FULL = (count == MEM_DEPTH)
  - EMPTY = (count == 0)
- Read latency, default build:
  - DATA_OUT registered; valid 1 cycle after the accepted read.
  - DATA_VALID pulses 1 cycle and is 0 after a rejected read.
  - DATA_OUT holds its last value when no read is accepted.
- Error bits:
  - CLR_ERR clears all OVERFLOW/UNDERFLOW bits.
  - If a set condition coincides with CLR_ERR, set wins.
- Per-channel ordering is strict FIFO. No ordering is defined across channels.

Optional Feature:
- Macro MC_SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - DATA_OUT = head entry of channel R_CH, combinational from the selected rd_ptr.
  - DATA_VALID = ~EMPTY[R_CH], also combinational.
  - An accepted R_EN pops the head; zero read latency.
- Not defined: the registered 1-cycle read path described above.
- All flag and error behaviour is identical in both builds.

Decomposition:
- Package mcf_pkg:
  - default parameter constants.
  - a chan_state_t struct {wr_ptr, rd_ptr, count}.
  - a function computing the pointer-width and count-width clog2 values.
- Sub-module mcf_chan_ctrl, instantiated NUM_CH times by generate. It owns:
  - pointers, count and wrap logic.
  - FULL/EMPTY/ALMOST flags.
  - sticky error bits.
- The top level owns the storage array, channel decode and read mux.

Test Plan:
- Reset then fill ch2 with 333 writes of data i+1 -> FULL[2]=1 after write 333, other channels EMPTY=1.
  - A 334th write sets OVERFLOW[2]=1 and count stays 333.
- Wrap on ch2: 200 writes, 200 reads, 200 writes, 200 reads -> read data matches order across the 332->0 wrap; EMPTY[2]=1 at end.
- Full ch1 with simultaneous write and read to ch1 -> write accepted, FULL[1] stays 1, count 333, OVERFLOW[1] stays 0.
- Empty ch0: read ch0 while writing ch0 -> read rejected, UNDERFLOW[0]=1, DATA_VALID=0; next cycle count[0]=1.
  - Then CLR_ERR -> UNDERFLOW=0.
- Concurrent write ch3 / read ch1 over 100 cycles -> both counts track independently.
  - ALMOST_EMPTY[3] deasserts at count 9.
  - ALMOST_FULL[1] deasserts when count drops to 319.
- RST_n low mid-burst, asynchronous to CLK -> all outputs reach reset values without a clock edge.
  - Post-reset read of ch2 is rejected.
  - Repeat both builds (MC_SYNC_FIFO_FWFT_EN on/off), checking 0 vs 1 cycle read latency.

Source files
------------

// File: rtl/mcf_pkg.sv
// mcf_pkg: default configuration, per-channel state record and width helpers
// shared by mc_sync_fifo and its channel controller.
package mcf_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_MEM_DEPTH     = 333;
  localparam int DEF_NUM_CH        = 4;
  localparam int DEF_AFULL_THRESH  = 320;
  localparam int DEF_AEMPTY_THRESH = 8;

  // Bits needed to address entries 0..depth-1 (never less than one bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Field width of the state record; wide enough for any depth up to 65535.
  localparam int STATE_W = cnt_width(65535);

  typedef struct packed {
    logic [STATE_W-1:0] wr_ptr;
    logic [STATE_W-1:0] rd_ptr;
    logic [STATE_W-1:0] count;
  } chan_state_t;

endpackage

// File: rtl/mcf_chan_ctrl.sv
// mcf_chan_ctrl: bookkeeping for one channel of mc_sync_fifo -- circular
// pointers with explicit wrap, occupancy count, registered level flags and
// sticky overflow/underflow bits.
module mcf_chan_ctrl
  import mcf_pkg::*;
#(
  parameter int MEM_DEPTH     = DEF_MEM_DEPTH,
  parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH,
  parameter int PTR_W         = ptr_width(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             ovf_set,
  input  logic             unf_set,
  input  logic             clr_err,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [STATE_W-1:0] ONE      = STATE_W'(1);
  localparam logic [STATE_W-1:0] LAST_IDX = STATE_W'(MEM_DEPTH - 1);
  localparam logic [STATE_W-1:0] FULL_CNT = STATE_W'(MEM_DEPTH);
  localparam logic [STATE_W-1:0] AF_CNT   = STATE_W'(AFULL_THRESH);
  localparam logic [STATE_W-1:0] AE_CNT   = STATE_W'(AEMPTY_THRESH);

  chan_state_t state_q, state_d;
  logic full_q, full_d, empty_q, empty_d;
  logic afull_q, afull_d, aempty_q, aempty_d;
  logic ovf_q, ovf_d, unf_q, unf_d;

  // Next pointers and count: wrap at the last index, count holds on push+pop.
  // NOTE: combinational blocks use blocking '=' and give every target a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (push) state_d.wr_ptr = (state_q.wr_ptr == LAST_IDX) ? '0 : state_q.wr_ptr + ONE;
    if (pop)  state_d.rd_ptr = (state_q.rd_ptr == LAST_IDX) ? '0 : state_q.rd_ptr + ONE;
    if (push && !pop)      state_d.count = state_q.count + ONE;
    else if (pop && !push) state_d.count = state_q.count - ONE;
  end

  // Flags follow the next-state count; a set request beats a simultaneous clear.
  always_comb begin
    full_d   = (state_d.count == FULL_CNT);
    empty_d  = (state_d.count == '0);
    afull_d  = (state_d.count >= AF_CNT);
    aempty_d = (state_d.count <= AE_CNT);
    ovf_d    = ovf_set | (ovf_q & ~clr_err);
    unf_d    = unf_set | (unf_q & ~clr_err);
  end

  // Channel state registers; reset empties the queue and clears the errors.
  // NOTE: sequential blocks use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign wr_ptr       = state_q.wr_ptr[PTR_W-1:0];
  assign rd_ptr       = state_q.rd_ptr[PTR_W-1:0];
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: rtl/mc_sync_fifo.sv
// mc_sync_fifo: single-clock FIFO holding NUM_CH independent circular queues
// in one storage array. The caller picks a channel per write and per read.
// Build option MC_SYNC_FIFO_FWFT_EN: first-word-fall-through read port
// (head of R_CH shown combinationally); otherwise the read data is registered
// and valid one cycle after an accepted read.
module mc_sync_fifo
  import mcf_pkg::*;
#(
  parameter  int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter  int MEM_DEPTH     = DEF_MEM_DEPTH,
  parameter  int NUM_CH        = DEF_NUM_CH,
  parameter  int AFULL_THRESH  = DEF_AFULL_THRESH,
  parameter  int AEMPTY_THRESH = DEF_AEMPTY_THRESH,
  localparam int CHW           = $clog2(NUM_CH)
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  W_EN,
  input  logic [CHW-1:0]        W_CH,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  R_EN,
  input  logic [CHW-1:0]        R_CH,
  input  logic                  CLR_ERR,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  DATA_VALID,
  output logic [NUM_CH-1:0]     FULL,
  output logic [NUM_CH-1:0]     EMPTY,
  output logic [NUM_CH-1:0]     ALMOST_FULL,
  output logic [NUM_CH-1:0]     ALMOST_EMPTY,
  output logic [NUM_CH-1:0]     OVERFLOW,
  output logic [NUM_CH-1:0]     UNDERFLOW
);

  localparam int PTR_W = ptr_width(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [NUM_CH][MEM_DEPTH];
  logic [PTR_W-1:0]      wr_ptr [NUM_CH];
  logic [PTR_W-1:0]      rd_ptr [NUM_CH];
  logic                  rd_accept, wr_accept;
  logic [NUM_CH-1:0]     push, pop, ovf_set, unf_set;
  logic [DATA_WIDTH-1:0] head_data;

  // Accept/reject decisions and per-channel decode. A full channel still takes
  // a write when the same cycle pops it; an empty channel never bypasses.
  always_comb begin
    rd_accept = R_EN & ~EMPTY[R_CH];
    wr_accept = W_EN & (~FULL[W_CH] | (rd_accept & (R_CH == W_CH)));
    push      = '0;
    pop       = '0;
    ovf_set   = '0;
    unf_set   = '0;
    push[W_CH]    = wr_accept;
    pop[R_CH]     = rd_accept;
    ovf_set[W_CH] = W_EN & ~wr_accept;
    unf_set[R_CH] = R_EN & ~rd_accept;
  end

  // Shared storage, written at the selected channel's write pointer.
  // NOTE: the data array has no reset; only pointers and flags define what is valid.
  always_ff @(posedge CLK) begin
    if (wr_accept) mem_q[W_CH][wr_ptr[W_CH]] <= DATA_IN;
  end

  assign head_data = mem_q[R_CH][rd_ptr[R_CH]];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mcf_chan_ctrl #(
      .MEM_DEPTH     (MEM_DEPTH),
      .AFULL_THRESH  (AFULL_THRESH),
      .AEMPTY_THRESH (AEMPTY_THRESH),
      .PTR_W         (PTR_W)
    ) u_ctrl (
      .clk          (CLK),
      .rst_n        (RST_n),
      .push         (push[c]),
      .pop          (pop[c]),
      .ovf_set      (ovf_set[c]),
      .unf_set      (unf_set[c]),
      .clr_err      (CLR_ERR),
      .wr_ptr       (wr_ptr[c]),
      .rd_ptr       (rd_ptr[c]),
      .full         (FULL[c]),
      .empty        (EMPTY[c]),
      .almost_full  (ALMOST_FULL[c]),
      .almost_empty (ALMOST_EMPTY[c]),
      .overflow     (OVERFLOW[c]),
      .underflow    (UNDERFLOW[c])
    );
  end

`ifdef MC_SYNC_FIFO_FWFT_EN
  // Head of the selected channel, forced to zero while that channel is empty.
  always_comb begin
    DATA_VALID = ~EMPTY[R_CH];
    DATA_OUT   = EMPTY[R_CH] ? '0 : head_data;
  end
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;

  // Capture the popped entry; hold the last value when nothing is popped.
  always_comb begin
    data_out_d   = rd_accept ? head_data : data_out_q;
    data_valid_d = rd_accept;
  end

  // Registered read port.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign DATA_OUT   = data_out_q;
  assign DATA_VALID = data_valid_q;
`endif

endmodule

// File: tb/tb_mc_sync_fifo.sv
// tb_mc_sync_fifo: directed bench for mc_sync_fifo (default parameters).
// A short vector table covers single-cycle behaviour; longer sequences use a
// per-channel queue model for data and flag expectations.
module tb_mc_sync_fifo;

  localparam int NCH   = 4;
  localparam int DEPTH = 333;
  localparam int AF    = 320;

  logic       CLK = 1'b0, RST_n = 1'b1;
  logic       W_EN = 1'b0, R_EN = 1'b0, CLR_ERR = 1'b0;
  logic [1:0] W_CH = 2'd0, R_CH = 2'd0;
  logic [7:0] DATA_IN = 8'h00;
  logic [7:0] DATA_OUT;
  logic       DATA_VALID;
  logic [3:0] FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;

  mc_sync_fifo dut (
    .CLK(CLK), .RST_n(RST_n), .W_EN(W_EN), .W_CH(W_CH), .DATA_IN(DATA_IN),
    .R_EN(R_EN), .R_CH(R_CH), .CLR_ERR(CLR_ERR), .DATA_OUT(DATA_OUT),
    .DATA_VALID(DATA_VALID), .FULL(FULL), .EMPTY(EMPTY),
    .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         m_cnt [NCH];
  logic [7:0] mq [NCH][$];
  logic [3:0] m_ovf, m_unf;
  logic [7:0] m_last;

  typedef struct {
    logic       we;  logic [1:0] wc; logic [7:0] din;
    logic       re;  logic [1:0] rc; logic       clr;
    logic       exp_valid; logic [7:0] exp_dout;
    logic [3:0] exp_empty; logic [3:0] exp_unf;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] exp_flags();
    logic [3:0] f, e, af, ae;
    for (int c = 0; c < NCH; c++) begin
      f[c]  = (m_cnt[c] == DEPTH);
      e[c]  = (m_cnt[c] == 0);
      af[c] = (m_cnt[c] >= AF);
      ae[c] = (m_cnt[c] <= 8);
    end
    return {8'h00, f, e, af, ae, m_ovf, m_unf};
  endfunction

  function automatic logic [31:0] act_flags();
    return {8'h00, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW};
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0;
      mq[c].delete();
    end
    m_ovf  = 4'h0;
    m_unf  = 4'h0;
    m_last = 8'h00;
  endtask

  // One clock of stimulus, checked against the queue model.
  task automatic op(input logic we, input int wc, input logic [7:0] d,
                    input logic re, input int rc, input logic clr, input string tag);
    logic rd_ok, wr_ok;
    rd_ok = re && (m_cnt[rc] != 0);
    wr_ok = we && ((m_cnt[wc] != DEPTH) || (rd_ok && rc == wc));
    W_EN = we; W_CH = 2'(wc); DATA_IN = d; R_EN = re; R_CH = 2'(rc); CLR_ERR = clr;
`ifdef MC_SYNC_FIFO_FWFT_EN
    #1;
    check({tag, "_valid"}, 32'(DATA_VALID), 32'(m_cnt[rc] != 0));
    if (m_cnt[rc] != 0) check({tag, "_data"}, 32'(DATA_OUT), 32'(mq[rc][0]));
`endif
    if (rd_ok) begin
      m_last = mq[rc].pop_front();
      m_cnt[rc]--;
    end
    if (wr_ok) begin
      mq[wc].push_back(d);
      m_cnt[wc]++;
    end
    if (clr) begin
      m_ovf = 4'h0;
      m_unf = 4'h0;
    end
    if (we && !wr_ok) m_ovf[wc] = 1'b1;
    if (re && !rd_ok) m_unf[rc] = 1'b1;
    step();
`ifndef MC_SYNC_FIFO_FWFT_EN
    check({tag, "_valid"}, 32'(DATA_VALID), 32'(rd_ok));
    check({tag, "_data"}, 32'(DATA_OUT), 32'(m_last));
`endif
    check({tag, "_flags"}, act_flags(), exp_flags());
    W_EN = 1'b0; R_EN = 1'b0; CLR_ERR = 1'b0;
  endtask

  task automatic do_reset();
    W_EN = 1'b0; R_EN = 1'b0; CLR_ERR = 1'b0;
    #2;
    RST_n = 1'b0;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    RST_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    // Asynchronous reset before any clock edge.
    #1 RST_n = 1'b0;
    #1;
    check("rst_empty",  32'(EMPTY),        32'hF);
    check("rst_aempty", 32'(ALMOST_EMPTY), 32'hF);
    check("rst_full",   32'(FULL),         32'h0);
    check("rst_afull",  32'(ALMOST_FULL),  32'h0);
    check("rst_ovf",    32'(OVERFLOW),     32'h0);
    check("rst_unf",    32'(UNDERFLOW),    32'h0);
    check("rst_dout",   32'(DATA_OUT),     32'h0);
    check("rst_valid",  32'(DATA_VALID),   32'h0);
    repeat (2) @(posedge CLK);
    #1 RST_n = 1'b1;

    // Single-cycle vectors: {we,wc,din, re,rc,clr, valid,dout, empty,unf}.
    vecs[0] = '{1'b1, 2'd0, 8'hA1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 4'b1110, 4'b0000};
    vecs[1] = '{1'b1, 2'd1, 8'hB1, 1'b1, 2'd0, 1'b0, 1'b1, 8'hA1, 4'b1101, 4'b0000};
    vecs[2] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 8'hA1, 4'b1101, 4'b0000};
    vecs[3] = '{1'b1, 2'd3, 8'hC3, 1'b1, 2'd3, 1'b0, 1'b0, 8'hA1, 4'b0101, 4'b1000};
    vecs[4] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 1'b1, 8'hB1, 4'b0111, 4'b0000};
    vecs[5] = '{1'b1, 2'd3, 8'hC4, 1'b1, 2'd3, 1'b0, 1'b1, 8'hC3, 4'b0111, 4'b0000};
    vecs[6] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0, 1'b1, 8'hC4, 4'b1111, 4'b0000};
    vecs[7] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 1'b0, 8'hC4, 4'b1111, 4'b0100};
    vecs[8] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 8'hC4, 4'b1111, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      W_EN = vecs[i].we; W_CH = vecs[i].wc; DATA_IN = vecs[i].din;
      R_EN = vecs[i].re; R_CH = vecs[i].rc; CLR_ERR = vecs[i].clr;
      step();
`ifndef MC_SYNC_FIFO_FWFT_EN
      check($sformatf("vec%0d_valid", i), 32'(DATA_VALID), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_dout", i),  32'(DATA_OUT),   32'(vecs[i].exp_dout));
`endif
      check($sformatf("vec%0d_empty", i), 32'(EMPTY),     32'(vecs[i].exp_empty));
      check($sformatf("vec%0d_unf", i),   32'(UNDERFLOW), 32'(vecs[i].exp_unf));
    end
    do_reset();

    // Fill channel 2 to the brim, then overflow it.
    for (int i = 0; i < DEPTH; i++) begin
      op(1'b1, 2, 8'(i + 1), 1'b0, 0, 1'b0, "fill2");
      if (i == AF - 2)    check("fill2_afull_at_319", 32'(ALMOST_FULL), 32'h0);
      if (i == AF - 1)    check("fill2_afull_at_320", 32'(ALMOST_FULL), 32'h4);
      if (i == DEPTH - 2) check("fill2_not_full_332", 32'(FULL),        32'h0);
    end
    check("fill2_full",  32'(FULL),  32'h4);
    check("fill2_empty", 32'(EMPTY), 32'hB);
    op(1'b1, 2, 8'hEE, 1'b0, 0, 1'b0, "ovf2");
    check("ovf2_flag",       32'(OVERFLOW), 32'h4);
    check("ovf2_still_full", 32'(FULL),     32'h4);
    for (int i = 0; i < DEPTH; i++) op(1'b0, 0, 8'h00, 1'b1, 2, 1'b0, "drain2");
    check("drain2_empty", 32'(EMPTY[2]), 32'h1);
    op(1'b0, 0, 8'h00, 1'b0, 0, 1'b1, "clr_ovf");
    check("clr_ovf_flag", 32'(OVERFLOW), 32'h0);

    // Two passes of 200 on channel 2; the second crosses the 332 -> 0 wrap.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 200; i++) op(1'b1, 2, 8'(p * 200 + i), 1'b0, 0, 1'b0, "wrap_wr");
      for (int i = 0; i < 200; i++) op(1'b0, 0, 8'h00, 1'b1, 2, 1'b0, "wrap_rd");
    end
    check("wrap_empty", 32'(EMPTY[2]), 32'h1);

    // Full channel 1 with a same-cycle write and read.
    for (int i = 0; i < DEPTH; i++) op(1'b1, 1, 8'(i * 3), 1'b0, 0, 1'b0, "fill1");
    op(1'b1, 1, 8'h55, 1'b1, 1, 1'b0, "wr_rd_full1");
    check("wr_rd_full1_full", 32'(FULL),     32'h2);
    check("wr_rd_full1_ovf",  32'(OVERFLOW), 32'h0);

    // Empty channel 0: read with same-cycle write is rejected.
    op(1'b1, 0, 8'h3C, 1'b1, 0, 1'b0, "rd_wr_empty0");
    check("rd_wr_empty0_unf",   32'(UNDERFLOW), 32'h1);
    check("rd_wr_empty0_count", 32'(EMPTY[0]),  32'h0);
`ifndef MC_SYNC_FIFO_FWFT_EN
    check("rd_wr_empty0_valid", 32'(DATA_VALID), 32'h0);
`endif
    op(1'b0, 0, 8'h00, 1'b0, 0, 1'b1, "clr_unf");
    check("clr_unf_flag", 32'(UNDERFLOW), 32'h0);

    // Concurrent write ch3 / read ch1.
    for (int k = 1; k <= 100; k++) begin
      op(1'b1, 3, 8'(k), 1'b1, 1, 1'b0, "conc");
      if (k == 8)  check("conc_aempty3_cnt8",  32'(ALMOST_EMPTY[3]), 32'h1);
      if (k == 9)  check("conc_aempty3_cnt9",  32'(ALMOST_EMPTY[3]), 32'h0);
      if (k == 13) check("conc_afull1_cnt320", 32'(ALMOST_FULL[1]),  32'h1);
      if (k == 14) check("conc_afull1_cnt319", 32'(ALMOST_FULL[1]),  32'h0);
    end

    // Asynchronous reset in the middle of a burst, between clock edges.
    op(1'b0, 0, 8'h00, 1'b1, 2, 1'b0, "pre_rst_unf");
    W_EN = 1'b1; W_CH = 2'd2; DATA_IN = 8'h99; R_EN = 1'b1; R_CH = 2'd1;
    @(posedge CLK);
    #3 RST_n = 1'b0;
    #1;
    check("arst_empty",  32'(EMPTY),        32'hF);
    check("arst_aempty", 32'(ALMOST_EMPTY), 32'hF);
    check("arst_full",   32'(FULL),         32'h0);
    check("arst_afull",  32'(ALMOST_FULL),  32'h0);
    check("arst_ovf",    32'(OVERFLOW),     32'h0);
    check("arst_unf",    32'(UNDERFLOW),    32'h0);
    check("arst_dout",   32'(DATA_OUT),     32'h0);
    check("arst_valid",  32'(DATA_VALID),   32'h0);
    W_EN = 1'b0; R_EN = 1'b0;
    model_clear();
    repeat (2) @(posedge CLK);
    #1 RST_n = 1'b1;
    op(1'b0, 0, 8'h00, 1'b1, 2, 1'b0, "post_rst_rd2");
    check("post_rst_rd2_unf", 32'(UNDERFLOW), 32'h4);
`ifndef MC_SYNC_FIFO_FWFT_EN
    check("post_rst_rd2_valid", 32'(DATA_VALID), 32'h0);
`endif
    op(1'b1, 0, 8'h77, 1'b0, 0, 1'b0, "post_rst_wr0");
    check("post_rst_wr0_entry0", 32'(dut.mem_q[0][0]), 32'h77);
    op(1'b0, 0, 8'h00, 1'b1, 0, 1'b0, "post_rst_rd0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
